so3s_otfc_ctrl: RTL and testbench

SO3S_OTFC_CTRL -- requirements
Module: so3s_otfc_ctrl

---
 rtl/so3s_otfc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_so3s_otfc_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/so3s_otfc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : so3s_otfc_ctrl
// Purpose  : On-the-fly converter controller. It turns a redundant signed-digit
//            stream into two's-complement Q/QM registers after DELTA warm digits.
// Option   : define SO3S_OTFC_ERR_EN to add the sticky digit_err output.
// Revision : 1.0 - initial release
// ============================================================================

package rbr_pkg;
  typedef struct packed {
    logic plus;
    logic minus;
  } signed_digit;
endpackage

module so3s_otfc_ctrl #(
  parameter int X_WIDTH = 8,
  parameter int WIDTH   = 11,
  parameter int DELTA   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  rbr_pkg::signed_digit                 x,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic                                 append_en,
  output logic [$clog2(X_WIDTH+DELTA+1)-1:0]   j_idx,
  output logic                                 busy,
  output logic [WIDTH-1:0]                     q_out,
  output logic [WIDTH-1:0]                     qm_out,
  output logic                                 result_valid,
  input  logic                                 result_ready
`ifdef SO3S_OTFC_ERR_EN
  ,
  output logic                                 digit_err
`endif
);

  localparam int c_cnt_w = $clog2(X_WIDTH + DELTA + 1);
  // QM starts at -1 ulp of the integer part: ones above the fraction field.
  localparam logic [WIDTH-1:0]   c_qm_init   = ~((WIDTH'(1) << X_WIDTH) - WIDTH'(1));
  localparam logic [c_cnt_w-1:0] c_warm_last = c_cnt_w'((DELTA > 0) ? DELTA - 1 : 0);
  localparam logic [c_cnt_w-1:0] c_run_last  = c_cnt_w'(X_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_qm;
  logic [WIDTH-1:0]     w_q_nxt;
  logic [WIDTH-1:0]     w_qm_nxt;
  logic [WIDTH-1:0]     w_bit;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 w_plus;
  logic                 w_minus;

  // Digits with both or neither field set collapse to zero.
  assign w_plus  = x.plus & ~x.minus;
  assign w_minus = x.minus & ~x.plus;
  assign w_bit   = WIDTH'(1) << (c_run_last - r_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_qm    <= c_qm_init;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_qm    <= w_qm_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_qm_nxt     = r_qm;
    w_cnt_nxt    = r_cnt;
    in_ready     = 1'b0;
    append_en    = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_q_nxt     = '0;
          w_qm_nxt    = c_qm_init;
          w_cnt_nxt   = '0;
          w_state_nxt = (DELTA > 0) ? ST_WARM : ST_RUN;
        end
      end
      ST_WARM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (r_cnt == c_warm_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_RUN: begin
        in_ready  = 1'b1;
        append_en = in_valid;
        if (in_valid) begin
          if (w_plus) begin
            w_q_nxt  = r_q | w_bit;
            w_qm_nxt = r_q;
          end else if (w_minus) begin
            w_q_nxt  = r_qm | w_bit;
            w_qm_nxt = r_qm;
          end else begin
            w_qm_nxt = r_qm | w_bit;
          end
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == c_run_last) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign q_out  = r_q;
  assign qm_out = r_qm;
  assign j_idx  = r_cnt;

`ifdef SO3S_OTFC_ERR_EN
  logic r_digit_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit_err <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_digit_err <= 1'b0;
    end else if (r_state == ST_RUN && in_valid && x.plus && x.minus) begin
      r_digit_err <= 1'b1;
    end
  end

  assign digit_err = r_digit_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_so3s_otfc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_so3s_otfc_ctrl
// Purpose  : Directed self-checking bench for so3s_otfc_ctrl at default sizes.
// Revision : 1.0 - initial release
// ============================================================================

module tb_so3s_otfc_ctrl;

  localparam int X_WIDTH = 8;
  localparam int WIDTH   = 11;
  localparam int DELTA   = 2;
  localparam logic [1:0] D_P = 2'b10;
  localparam logic [1:0] D_M = 2'b01;
  localparam logic [1:0] D_Z = 2'b00;
  localparam logic [1:0] D_E = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  rbr_pkg::signed_digit x;
  logic                 in_valid;
  logic                 in_ready;
  logic                 append_en;
  logic [3:0]           j_idx;
  logic                 busy;
  logic [WIDTH-1:0]     q_out;
  logic [WIDTH-1:0]     qm_out;
  logic                 result_valid;
  logic                 result_ready;
`ifdef SO3S_OTFC_ERR_EN
  logic                 digit_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  so3s_otfc_ctrl #(.X_WIDTH(X_WIDTH), .WIDTH(WIDTH), .DELTA(DELTA)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .x            (x),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .append_en    (append_en),
    .j_idx        (j_idx),
    .busy         (busy),
    .q_out        (q_out),
    .qm_out       (qm_out),
    .result_valid (result_valid),
    .result_ready (result_ready)
`ifdef SO3S_OTFC_ERR_EN
    ,
    .digit_err    (digit_err)
`endif
  );

  task automatic set_digit(input logic [1:0] d);
    x = rbr_pkg::signed_digit'(d);
  endtask

  // Two warm digits followed by eight run digits, first digit in the low bits.
  function automatic logic [19:0] seq10(input logic [1:0] w0, input logic [1:0] w1,
                                        input logic [1:0] r0, input logic [1:0] r1,
                                        input logic [1:0] r2, input logic [1:0] r3,
                                        input logic [1:0] r4, input logic [1:0] r5,
                                        input logic [1:0] r6, input logic [1:0] r7);
    return {r7, r6, r5, r4, r3, r2, r1, r0, w1, w0};
  endfunction

  // Start and stream digits back to back; lat counts edges after the start edge.
  task automatic run_conv(input logic [19:0] seq, output int lat);
    start = 1'b1; in_valid = 1'b1; set_digit(D_Z);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 0; k < 40 && !result_valid; k++) begin
      set_digit((k < 10) ? seq[2*k +: 2] : D_Z);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic handoff();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic abort_rst();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; result_ready = 1'b0; set_digit(D_Z);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (append_en !== 1'b0) begin n_fail++; $display("FAIL rst_append_en: got %b expected 0", append_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_result_valid: got %b expected 0", result_valid); end
    n_checks++; if (j_idx !== 4'd0) begin n_fail++; $display("FAIL rst_j_idx: got %0d expected 0", j_idx); end
    n_checks++; if (q_out !== 11'h000) begin n_fail++; $display("FAIL rst_q: got %h expected 000", q_out); end
    n_checks++; if (qm_out !== 11'h700) begin n_fail++; $display("FAIL rst_qm: got %h expected 700", qm_out); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_warm();
    start = 1'b1; in_valid = 1'b1; set_digit(D_P);
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL warm_flags: got busy %b in_ready %b expected 1 1", busy, in_ready); end
    n_checks++; if (append_en !== 1'b0) begin n_fail++; $display("FAIL warm_append: got %b expected 0", append_en); end
    set_digit(D_M);
    @(posedge clk); #1;
    n_checks++; if (j_idx !== 4'd1 || q_out !== 11'h000 || qm_out !== 11'h700) begin
      n_fail++; $display("FAIL warm_discard: got j %0d q %h qm %h expected 1 000 700", j_idx, q_out, qm_out); end
    set_digit(D_P);
    @(posedge clk); #1;
    n_checks++; if (j_idx !== 4'd0 || append_en !== 1'b1) begin
      n_fail++; $display("FAIL run_entry: got j %0d append %b expected 0 1", j_idx, append_en); end
    abort_rst();
    in_valid = 1'b0;
  endtask

  task automatic test_pos_half();
    int lat;
    run_conv(seq10(D_M, D_P, D_P, D_Z, D_Z, D_Z, D_Z, D_Z, D_Z, D_Z), lat);
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL latency: got %0d edges expected 10", lat); end
    n_checks++; if (q_out !== 11'h080) begin n_fail++; $display("FAIL pos_half_q: got %h expected 080", q_out); end
    n_checks++; if (qm_out !== 11'h07f) begin n_fail++; $display("FAIL pos_half_qm: got %h expected 07f", qm_out); end
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || j_idx !== 4'd8) begin
      n_fail++; $display("FAIL done_flags: got in_ready %b busy %b j %0d expected 0 1 8", in_ready, busy, j_idx); end
    handoff();
    n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL handoff: got busy %b valid %b expected 0 0", busy, result_valid); end
    n_checks++; if (q_out !== 11'h080) begin n_fail++; $display("FAIL idle_hold_q: got %h expected 080", q_out); end
  endtask

  task automatic test_neg_half();
    int lat;
    run_conv(seq10(D_P, D_P, D_M, D_Z, D_Z, D_Z, D_Z, D_Z, D_Z, D_Z), lat);
    n_checks++; if (q_out !== 11'h780) begin n_fail++; $display("FAIL neg_half_q: got %h expected 780", q_out); end
    n_checks++; if (qm_out !== 11'h77f) begin n_fail++; $display("FAIL neg_half_qm: got %h expected 77f", qm_out); end
    handoff();
  endtask

  task automatic test_pos_neg();
    int lat;
    run_conv(seq10(D_Z, D_Z, D_P, D_M, D_E, D_Z, D_Z, D_Z, D_Z, D_Z), lat);
    n_checks++; if (q_out !== 11'h040) begin n_fail++; $display("FAIL pos_neg_q: got %h expected 040", q_out); end
    n_checks++; if (qm_out !== 11'h03f) begin n_fail++; $display("FAIL pos_neg_qm: got %h expected 03f", qm_out); end
    handoff();
  endtask

  task automatic test_all_minus();
    int lat;
    run_conv(seq10(D_Z, D_Z, D_M, D_M, D_M, D_M, D_M, D_M, D_M, D_M), lat);
    n_checks++; if (q_out !== 11'h701) begin n_fail++; $display("FAIL all_minus_q: got %h expected 701", q_out); end
    n_checks++; if (qm_out !== 11'h700) begin n_fail++; $display("FAIL all_minus_qm: got %h expected 700", qm_out); end
    handoff();
  endtask

  task automatic test_stall();
    logic [19:0] seq;
    int di;
    int stalls;
    int lat;
    seq = seq10(D_Z, D_Z, D_P, D_Z, D_M, D_Z, D_Z, D_Z, D_Z, D_Z);
    di = 0; stalls = 0; lat = 0;
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 40 && !result_valid; k++) begin
      if (di == 5 && stalls < 3) begin
        in_valid = 1'b0; stalls++;
        #1;
        n_checks++; if (append_en !== 1'b0) begin n_fail++; $display("FAIL stall_append: got %b expected 0", append_en); end
        @(posedge clk); #1;
        lat++;
        n_checks++; if (j_idx !== 4'd3) begin n_fail++; $display("FAIL stall_j: got %0d expected 3", j_idx); end
        n_checks++; if (q_out !== 11'h060) begin n_fail++; $display("FAIL stall_q: got %h expected 060", q_out); end
        n_checks++; if (qm_out !== 11'h040) begin n_fail++; $display("FAIL stall_qm: got %h expected 040", qm_out); end
      end else begin
        in_valid = 1'b1;
        set_digit((di < 10) ? seq[2*di +: 2] : D_Z);
        @(posedge clk); #1;
        lat++; di++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL stall_latency: got %0d edges expected 13", lat); end
    n_checks++; if (q_out !== 11'h060 || qm_out !== 11'h05f) begin
      n_fail++; $display("FAIL stall_result: got q %h qm %h expected 060 05f", q_out, qm_out); end
    handoff();
  endtask

  task automatic test_reset_mid_run();
    logic [11:0] seq;
    seq = {D_P, D_Z, D_M, D_P, D_Z, D_Z};
    start = 1'b1; in_valid = 1'b1; set_digit(D_Z);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_digit(seq[2*k +: 2]);
      @(posedge clk); #1;
    end
    n_checks++; if (j_idx !== 4'd4 || q_out !== 11'h050 || qm_out !== 11'h040) begin
      n_fail++; $display("FAIL mid_run: got j %0d q %h qm %h expected 4 050 040", j_idx, q_out, qm_out); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || append_en !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_flags: got busy %b rdy %b app %b val %b expected 0 0 0 0", busy, in_ready, append_en, result_valid); end
    n_checks++; if (j_idx !== 4'd0 || q_out !== 11'h000 || qm_out !== 11'h700) begin
      n_fail++; $display("FAIL async_rst_regs: got j %0d q %h qm %h expected 0 000 700", j_idx, q_out, qm_out); end
    start = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || j_idx !== 4'd0) begin
      n_fail++; $display("FAIL first_edge_idle: got busy %b rdy %b j %0d expected 1 1 0", busy, in_ready, j_idx); end
    abort_rst();
    in_valid = 1'b0;
  endtask

  task automatic test_start_in_done();
    int lat;
    run_conv(seq10(D_Z, D_Z, D_Z, D_Z, D_Z, D_Z, D_Z, D_Z, D_Z, D_Z), lat);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (result_valid !== 1'b1 || q_out !== 11'h000 || qm_out !== 11'h7ff) begin
      n_fail++; $display("FAIL done_ignores_start: got val %b q %h qm %h expected 1 000 7ff", result_valid, q_out, qm_out); end
    handoff();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL handoff_ignores_start: got busy %b expected 0", busy); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0 || qm_out !== 11'h7ff) begin
      n_fail++; $display("FAIL idle_hold: got busy %b qm %h expected 0 7ff", busy, qm_out); end
  endtask

`ifdef SO3S_OTFC_ERR_EN
  task automatic test_digit_err();
    int lat;
    n_checks++; if (digit_err !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b expected 0", digit_err); end
    run_conv(seq10(D_E, D_E, D_Z, D_Z, D_E, D_Z, D_Z, D_Z, D_Z, D_Z), lat);
    n_checks++; if (digit_err !== 1'b1) begin n_fail++; $display("FAIL err_done: got %b expected 1", digit_err); end
    n_checks++; if (q_out !== 11'h000 || qm_out !== 11'h7ff) begin
      n_fail++; $display("FAIL err_as_zero: got q %h qm %h expected 000 7ff", q_out, qm_out); end
    handoff();
    n_checks++; if (digit_err !== 1'b1) begin n_fail++; $display("FAIL err_idle_sticky: got %b expected 1", digit_err); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (digit_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", digit_err); end
    abort_rst();
  endtask
`endif

  initial begin
    test_reset();
    test_warm();
    test_pos_half();
    test_neg_half();
    test_pos_neg();
    test_all_minus();
    test_stall();
    test_reset_mid_run();
    test_start_in_done();
`ifdef SO3S_OTFC_ERR_EN
    test_digit_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
